// File: rtl/barramento_ctrl_if.sv
// barramento_ctrl_if: request/ctrl handshake between the control unit (master) and the transfer sequencer (slave)
interface barramento_ctrl_if;
  logic       req_valid;
  logic [2:0] req_src;
  logic [2:0] req_dst;
  logic       req_ready;
  logic [1:0] ctrl_0;
  logic [1:0] ctrl_1;
  logic [1:0] ctrl_2;
  logic [1:0] ctrl_3;
  logic [1:0] ctrl_4;
  logic [1:0] ctrl_5;
  logic       done;
  logic [2:0] done_dst;
  logic       err;
  logic       busy;
  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5, done, done_dst, err, busy
  );
  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5, done, done_dst, err, busy
  );
endinterface

// File: rtl/barramento_ctrl.sv
// barramento_ctrl: six-port bus transfer sequencer; define BARRAMENTO_STATS_EN for xfer/err counters.
// Stages S[0..READ_DELAY-1] are held in v_q/dst_q; S[READ_DELAY] lives in the registered outputs.
module barramento_ctrl #(
  parameter int READ_DELAY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  barramento_ctrl_if.slave     bus
`ifdef BARRAMENTO_STATS_EN
  ,
  output logic [CNT_W-1:0]     xfer_count_o,
  output logic [7:0]           err_count_o
`endif
);
  localparam int RD = READ_DELAY;
  logic [RD-1:0]    v_q;
  logic [2:0]       dst_q [RD];
  logic [5:0][1:0]  ctrl_q, ctrl_d;
  logic             done_q, err_q, busy_q;
  logic [2:0]       done_dst_q;
  logic             ready, acc, ok, v0_d, err_d;
  always_comb begin
    ready = !(v_q[RD-1] && dst_q[RD-1] == bus.req_src);
    acc   = bus.req_valid && ready;
    ok    = bus.req_src < 3'd6 && bus.req_dst < 3'd6 && bus.req_src != bus.req_dst;
    v0_d  = acc && ok;
    err_d = acc && !ok;
    ctrl_d = '0;
    for (int x = 0; x < 6; x++)
      ctrl_d[x] = {v0_d && bus.req_src == 3'(x), v_q[RD-1] && dst_q[RD-1] == 3'(x)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q        <= '0;
      for (int k = 0; k < RD; k++) dst_q[k] <= '0;
      ctrl_q     <= '0;
      done_q     <= 1'b0;
      done_dst_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      v_q        <= RD'({v_q, v0_d});
      dst_q[0]   <= bus.req_dst;
      for (int k = 1; k < RD; k++) dst_q[k] <= dst_q[k-1];
      ctrl_q     <= ctrl_d;
      done_q     <= v_q[RD-1];
      done_dst_q <= v_q[RD-1] ? dst_q[RD-1] : 3'd0;
      err_q      <= err_d;
      busy_q     <= v0_d || |v_q;
    end
  end
`ifdef BARRAMENTO_STATS_EN
  logic [CNT_W-1:0] xfer_count_q;
  logic [7:0]       err_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      xfer_count_q <= xfer_count_q + CNT_W'(v_q[RD-1]);
      err_count_q  <= (err_d && err_count_q != 8'hff) ? err_count_q + 8'd1 : err_count_q;
    end
  end
  assign xfer_count_o = xfer_count_q;
  assign err_count_o  = err_count_q;
`endif
  assign bus.req_ready = ready;
  assign bus.ctrl_0    = ctrl_q[0];
  assign bus.ctrl_1    = ctrl_q[1];
  assign bus.ctrl_2    = ctrl_q[2];
  assign bus.ctrl_3    = ctrl_q[3];
  assign bus.ctrl_4    = ctrl_q[4];
  assign bus.ctrl_5    = ctrl_q[5];
  assign bus.done      = done_q;
  assign bus.done_dst  = done_dst_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_barramento_ctrl.sv
// tb_barramento_ctrl: directed stimulus, cycle-indexed expectation model and a small bus model
module tb_barramento_ctrl;
  localparam int RD = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  barramento_ctrl_if bus();
  barramento_ctrl #(.READ_DELAY(RD), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [1:0] ct [6];
  assign ct[0] = bus.ctrl_0;
  assign ct[1] = bus.ctrl_1;
  assign ct[2] = bus.ctrl_2;
  assign ct[3] = bus.ctrl_3;
  assign ct[4] = bus.ctrl_4;
  assign ct[5] = bus.ctrl_5;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // expectations indexed by cycle number (cycle e = the period after edge e)
  bit [5:0] wr [512];
  bit [5:0] rd [512];
  bit       dn [512];
  bit       er [512];
  bit       bz [512];
  bit [2:0] dd [512];
  int  cyc = 0;
  bit  chk_en = 0;
  function automatic bit m_ready(input int e, input logic [2:0] s);
    return s > 3'd5 || !rd[e][s];
  endfunction
  initial forever begin
    int e;
    @(posedge clk);
    e = cyc + 1;
    if (rst) begin
      chk_en = 1;
      for (int c = e; c < 512; c++) begin
        wr[c] = '0; rd[c] = '0; dn[c] = 0; er[c] = 0; bz[c] = 0; dd[c] = '0;
      end
    end else if (bus.req_valid && m_ready(e, bus.req_src)) begin
      if (bus.req_src < 6 && bus.req_dst < 6 && bus.req_src != bus.req_dst) begin
        wr[e][bus.req_src] = 1;
        rd[e+RD][bus.req_dst] = 1;
        dn[e+RD] = 1;
        dd[e+RD] = bus.req_dst;
        for (int k = 0; k <= RD; k++) bz[e+k] = 1;
      end else er[e] = 1;
    end
    cyc = e;
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int x = 0; x < 6; x++) chk($sformatf("ctrl_%0d@%0d", x, cyc), ct[x], {wr[cyc][x], rd[cyc][x]});
      chk($sformatf("done@%0d", cyc), bus.done, dn[cyc]);
      if (dn[cyc]) chk($sformatf("done_dst@%0d", cyc), bus.done_dst, dd[cyc]);
      chk($sformatf("err@%0d", cyc), bus.err, er[cyc]);
      chk($sformatf("busy@%0d", cyc), bus.busy, bz[cyc]);
      chk($sformatf("req_ready@%0d", cyc), bus.req_ready, m_ready(cyc + 1, bus.req_src));
    end
  end
  // bus: two registers between a writer and a reader; reader captures at the end of its read cycle
  logic [15:0] pd [6];
  logic [15:0] r1 = '0, r2 = '0;
  initial begin
    for (int x = 0; x < 6; x++) pd[x] = 16'h1000 + 16'(x);
    pd[2] = 16'hA5C3;
    forever begin
      logic [15:0] wd;
      @(negedge clk);
      wd = '0;
      for (int x = 0; x < 6; x++) if (ct[x][1]) wd = wd | pd[x];
      for (int x = 0; x < 6; x++) if (ct[x][0]) pd[x] = r2;
      r2 = r1;
      r1 = wd;
    end
  end
  task automatic issue(input logic [2:0] s, input logic [2:0] d, output int stalls);
    logic r;
    bus.req_valid = 1'b1; bus.req_src = s; bus.req_dst = d; stalls = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r = bus.req_ready;
      @(posedge clk); #1;
      if (r) return;
      stalls++;
    end
    n_chk++; n_fail++;
    $display("FAIL accept_timeout: request %0d->%0d never accepted", s, d);
  endtask
  task automatic idle_n(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int st, nd;
    bus.req_valid = 1'b1; bus.req_src = 3'd1; bus.req_dst = 3'd2;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ctrl1", ct[1], 0);
      chk("rst_busy", bus.busy, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_n(2);
    // single transfer 2->4
    issue(3'd2, 3'd4, st);
    bus.req_valid = 1'b0;
    @(negedge clk); chk("single_wr", ct[2], 2);
    @(negedge clk); chk("single_gap", {ct[0], ct[1], ct[2], ct[3], ct[4], ct[5]}, 0);
    @(negedge clk); chk("single_rd", ct[4], 1); chk("single_done", bus.done, 1); chk("single_dst", bus.done_dst, 4);
    @(negedge clk); chk("single_idle", bus.busy, 0);
    idle_n(1);
    chk("bus_capture", pd[4], 16'hA5C3);
    // back-to-back 0->1, 3->5
    issue(3'd0, 3'd1, st);
    issue(3'd3, 3'd5, st);
    chk("b2b_stall", st, 0);
    bus.req_valid = 1'b0;
    @(negedge clk); chk("b2b_wr3", ct[3], 2); chk("b2b_wr0_off", ct[0], 0);
    @(negedge clk); chk("b2b_rd1", ct[1], 1); chk("b2b_done1", bus.done, 1);
    @(negedge clk); chk("b2b_rd5", ct[5], 1); chk("b2b_done2", bus.done, 1);
    idle_n(3);
    // conflict: 1->2 presented while port 1 is about to be read
    issue(3'd0, 3'd1, st);
    idle_n(1);
    issue(3'd1, 3'd2, st);
    chk("conf_stalls", st, 1);
    bus.req_valid = 1'b0;
    @(negedge clk); chk("conf_wr1", ct[1], 2);
    idle_n(4);
    // invalid requests
    issue(3'd3, 3'd3, st);
    bus.req_valid = 1'b0;
    @(negedge clk); chk("inv_same_err", bus.err, 1); chk("inv_same_busy", bus.busy, 0);
    idle_n(1);
    issue(3'd6, 3'd0, st);
    bus.req_valid = 1'b0;
    @(negedge clk); chk("inv_range_err", bus.err, 1);
    chk("inv_ctrl", {ct[0], ct[1], ct[2], ct[3], ct[4], ct[5]}, 0);
    idle_n(2);
    // reset during the write cycle of 1->5
    issue(3'd1, 3'd5, st);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    chk("midrst_no_done", nd, 0);
    idle_n(1);
    issue(3'd4, 3'd0, st);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_done", bus.done, 1); chk("post_rst_dst", bus.done_dst, 0); chk("post_rst_rd0", ct[0], 1);
    idle_n(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
